// File: rtl/uart_rx_frame_if.sv
// Signal bundle between the UART RX framer, its baud counter and the
// APB-side register/FIFO logic. The framer connects through the master modport.
interface uart_rx_frame_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 enable;
  logic                 rx;
  logic                 tick;
  logic                 baud_en;
  logic                 kick;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  enable, rx, tick,
    output baud_en, kick, rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport slave (
    output enable, rx, tick,
    input  baud_en, kick, rx_data, rx_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises rx, kicks the baud counter on a start
// edge, shifts data LSB-first on ticks, then checks optional parity and stop.
module uart_rx_frame #(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            rst,
  uart_rx_frame_if.master rxf
);

  localparam int unsigned      CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_frame: DATA_BITS must be within 5..9");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HI
  } state_e;

  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic                 rx_prev_q;
  logic                 start_edge;

  state_e               state_q,      state_d;
  logic [CNT_W-1:0]     bit_cnt_q,    bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q,      shreg_d;
  logic                 par_bad_q,    par_bad_d;
  logic                 kick_q,       kick_d;
  logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
  logic                 rx_valid_q,   rx_valid_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 parity_err_q, parity_err_d;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxf.rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_s_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_bad_d    = par_bad_q;
    kick_d       = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    if (state_q != S_IDLE && !rxf.enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rxf.enable && start_edge) begin
            kick_d    = 1'b1;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (rxf.tick) begin
            shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = PARITY_EN ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (rxf.tick) begin
            par_bad_d = (^{shreg_q, rx_s_q}) ^ PARITY_ODD;
            state_d   = S_STOP;
          end
        end
        S_STOP: begin
          if (rxf.tick) begin
            rx_data_d    = shreg_q;
            rx_valid_d   = 1'b1;
            frame_err_d  = ~rx_s_q;
            parity_err_d = par_bad_q;
            state_d      = rx_s_q ? S_IDLE : S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      kick_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      kick_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      kick_q       <= kick_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rxf.baud_en    = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);
  assign rxf.busy       = (state_q != S_IDLE);
  assign rxf.kick       = kick_q;
  assign rxf.rx_data    = rx_data_q;
  assign rxf.rx_valid   = rx_valid_q;
  assign rxf.frame_err  = frame_err_q;
  assign rxf.parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: two instances (no parity / even parity), each
// paired with a 16-clk/bit baud counter, fed by a bit-level line driver.
module tb_uart_rx_frame;

  localparam int unsigned BIT_CLKS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  logic clk = 1'b0;
  logic arst;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_frame_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_frame_if #(.DATA_BITS(8)) bus1 ();

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
    .clk(clk), .arst(arst), .rst(rst), .rxf(bus0.master)
  );
  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .clk(clk), .arst(arst), .rst(rst), .rxf(bus1.master)
  );

  int   vecs = 0;
  int   fails = 0;
  logic inj0 = 1'b0;
  logic inj1 = 1'b0;
  logic [4:0] bc0, bc1;

  // Baud counters: kick loads 1.5 bit periods, then one tick per bit.
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      bc0 <= '0;
      bus0.tick <= 1'b0;
    end else begin
      bus0.tick <= inj0;
      if (bus0.kick) bc0 <= 5'd23;
      else if (bus0.baud_en) begin
        if (bc0 == 5'd0) begin
          bus0.tick <= 1'b1;
          bc0 <= 5'd15;
        end else bc0 <= bc0 - 5'd1;
      end
    end
  end

  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      bc1 <= '0;
      bus1.tick <= 1'b0;
    end else begin
      bus1.tick <= inj1;
      if (bus1.kick) bc1 <= 5'd23;
      else if (bus1.baud_en) begin
        if (bc1 == 5'd0) begin
          bus1.tick <= 1'b1;
          bc1 <= 5'd15;
        end else bc1 <= bc1 - 5'd1;
      end
    end
  end

  int   cyc = 0;
  int   last_tick0 = 0, last_tick1 = 0;
  rec_t q0[$], q1[$];
  int   lat0[$], lat1[$];
  int   kicks0 = 0;
  int   dbl_valid = 0;
  int   ben_off = 0;
  logic watch_off = 1'b0;
  logic prev_v0 = 1'b0, prev_v1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus0.tick === 1'b1) last_tick0 = cyc;
    if (bus1.tick === 1'b1) last_tick1 = cyc;
    if (bus0.rx_valid === 1'b1) begin
      q0.push_back('{d: bus0.rx_data, fe: bus0.frame_err, pe: bus0.parity_err});
      lat0.push_back(cyc - last_tick0);
    end
    if (bus1.rx_valid === 1'b1) begin
      q1.push_back('{d: bus1.rx_data, fe: bus1.frame_err, pe: bus1.parity_err});
      lat1.push_back(cyc - last_tick1);
    end
    if (bus0.rx_valid === 1'b1 && prev_v0 === 1'b1) dbl_valid++;
    if (bus1.rx_valid === 1'b1 && prev_v1 === 1'b1) dbl_valid++;
    prev_v0 = bus0.rx_valid;
    prev_v1 = bus1.rx_valid;
    if (bus0.kick === 1'b1) kicks0++;
    if (watch_off && (bus0.baud_en !== 1'b0 || bus0.kick !== 1'b0)) ben_off++;
  end

  // Expected result of one frame, from the line-level bit values.
  function automatic rec_t model(input logic [7:0] d, input logic par, input logic stop,
                                 input bit pen);
    rec_t r;
    int   ones;
    ones = $countones(d) + int'(par);
    r.d  = d;
    r.fe = (stop == 1'b0);
    r.pe = pen && ((ones % 2) != 0);
    return r;
  endfunction

  task automatic set_rx(input int which, input logic v);
    if (which == 0) bus0.rx = v;
    else bus1.rx = v;
  endtask

  // Drives start, data LSB-first, parity (instance 1 only), stop; leaves line at stop level.
  task automatic send_frame(input int which, input logic [7:0] d, input logic par,
                            input logic stop);
    set_rx(which, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, d[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (which == 1) begin
      set_rx(which, par);
      repeat (BIT_CLKS) @(negedge clk);
    end
    set_rx(which, stop);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus0.rx = 1'b1;  bus1.rx = 1'b1;
    bus0.enable = 1'b1; bus1.enable = 1'b1;
    arst = 1'b1;
    #2 arst = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({bus0.rx_data, bus0.rx_valid, bus0.frame_err, bus0.parity_err, bus0.busy,
         bus0.baud_en, bus0.kick} !== 14'h0) begin
      fails++;
      $display("FAIL reset_outs0 got %h want 0000", {bus0.rx_data, bus0.rx_valid,
               bus0.frame_err, bus0.parity_err, bus0.busy, bus0.baud_en, bus0.kick});
    end
    vecs++;
    if ({bus1.rx_data, bus1.rx_valid, bus1.frame_err, bus1.parity_err, bus1.busy,
         bus1.baud_en, bus1.kick} !== 14'h0) begin
      fails++;
      $display("FAIL reset_outs1 got %h want 0000", {bus1.rx_data, bus1.rx_valid,
               bus1.frame_err, bus1.parity_err, bus1.busy, bus1.baud_en, bus1.kick});
    end
    arst = 1'b1;
    repeat (6) @(negedge clk);
    vecs++;
    if (bus0.busy !== 1'b0 || bus0.kick !== 1'b0 || q0.size() != 0) begin
      fails++;
      $display("FAIL reset_release busy=%b kick=%b valids=%0d want 0 0 0",
               bus0.busy, bus0.kick, q0.size());
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    rec_t exp, got;
    int lat;
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      q0.delete(); lat0.delete();
      send_frame(0, d, 1'b0, 1'b1);
      repeat (8) @(negedge clk);
      exp = model(d, 1'b0, 1'b1, 1'b0);
      vecs++;
      if (q0.size() != 1) begin
        fails++;
        $display("FAIL basic_count[%0d] got %0d want 1", i, q0.size());
      end else begin
        got = q0.pop_front();
        lat = lat0.pop_front();
        vecs++;
        if (got !== exp) begin
          fails++;
          $display("FAIL basic_rec[%0d] got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b",
                   i, got.d, got.fe, got.pe, exp.d, exp.fe, exp.pe);
        end
        vecs++;
        if (lat != 1) begin
          fails++;
          $display("FAIL basic_latency[%0d] got %0d want 1", i, lat);
        end
      end
      repeat (20) @(negedge clk);
      vecs++;
      if (bus0.rx_data !== d || bus0.rx_valid !== 1'b0 || bus0.busy !== 1'b0) begin
        fails++;
        $display("FAIL basic_hold[%0d] got d=%h v=%b busy=%b want d=%h v=0 busy=0",
                 i, bus0.rx_data, bus0.rx_valid, bus0.busy, d);
      end
    end
  endtask

  task automatic test_break();
    rec_t exp, got;
    int k;
    q0.delete();
    inj0 = 1'b1;
    @(negedge clk);
    inj0 = 1'b0;
    repeat (4) @(negedge clk);
    vecs++;
    if (bus0.busy !== 1'b0 || q0.size() != 0) begin
      fails++;
      $display("FAIL idle_tick busy=%b valids=%0d want 0 0", bus0.busy, q0.size());
    end
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    k = kicks0;
    repeat (20) @(negedge clk);
    inj0 = 1'b1;
    @(negedge clk);
    inj0 = 1'b0;
    repeat (19) @(negedge clk);
    exp = model(8'h3C, 1'b0, 1'b0, 1'b0);
    vecs++;
    if (q0.size() != 1) begin
      fails++;
      $display("FAIL break_count got %0d want 1", q0.size());
    end else begin
      got = q0.pop_front();
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL break_rec got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b",
                 got.d, got.fe, got.pe, exp.d, exp.fe, exp.pe);
      end
    end
    vecs++;
    if (kicks0 != k || bus0.busy !== 1'b1 || bus0.baud_en !== 1'b0) begin
      fails++;
      $display("FAIL break_wait kicks=%0d busy=%b baud_en=%b want %0d 1 0",
               kicks0, bus0.busy, bus0.baud_en, k);
    end
    bus0.rx = 1'b1;
    repeat (20) @(negedge clk);
    vecs++;
    if (bus0.busy !== 1'b0 || q0.size() != 0) begin
      fails++;
      $display("FAIL break_release busy=%b valids=%0d want 0 0", bus0.busy, q0.size());
    end
    send_frame(0, 8'h81, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    exp = model(8'h81, 1'b0, 1'b1, 1'b0);
    vecs++;
    if (q0.size() != 1) begin
      fails++;
      $display("FAIL break_next_count got %0d want 1", q0.size());
    end else begin
      got = q0.pop_front();
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL break_next_rec got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b",
                 got.d, got.fe, got.pe, exp.d, exp.fe, exp.pe);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic par, stop;
    rec_t exp, got;
    int lat;
    for (int i = 0; i < 8; i++) begin
      if (i < 2) begin
        d = 8'h0F; par = (i == 1); stop = 1'b1;
      end else begin
        d = 8'($urandom); par = 1'($urandom); stop = ($urandom_range(0, 3) != 0);
      end
      q1.delete(); lat1.delete();
      send_frame(1, d, par, stop);
      bus1.rx = 1'b1;
      repeat (10) @(negedge clk);
      exp = model(d, par, stop, 1'b1);
      vecs++;
      if (q1.size() != 1) begin
        fails++;
        $display("FAIL parity_count[%0d] got %0d want 1", i, q1.size());
      end else begin
        got = q1.pop_front();
        lat = lat1.pop_front();
        vecs++;
        if (got !== exp || lat != 1) begin
          fails++;
          $display("FAIL parity_rec[%0d] got d=%h fe=%b pe=%b lat=%0d want d=%h fe=%b pe=%b lat=1",
                   i, got.d, got.fe, got.pe, lat, exp.d, exp.fe, exp.pe);
        end
      end
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] frames[6];
    rec_t exp, got;
    int lat;
    frames[0] = 8'h55;
    frames[1] = 8'hAA;
    for (int i = 2; i < 6; i++) frames[i] = 8'($urandom);
    q0.delete(); lat0.delete();
    dbl_valid = 0;
    for (int i = 0; i < 6; i++) send_frame(0, frames[i], 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    vecs++;
    if (q0.size() != 6) begin
      fails++;
      $display("FAIL b2b_count got %0d want 6", q0.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        got = q0.pop_front();
        lat = lat0.pop_front();
        exp = model(frames[i], 1'b0, 1'b1, 1'b0);
        vecs++;
        if (got !== exp || lat != 1) begin
          fails++;
          $display("FAIL b2b_rec[%0d] got d=%h fe=%b pe=%b lat=%0d want d=%h fe=0 pe=0 lat=1",
                   i, got.d, got.fe, got.pe, lat, exp.d);
        end
      end
    end
    vecs++;
    if (dbl_valid != 0) begin
      fails++;
      $display("FAIL b2b_pulse_width got %0d wide pulses want 0", dbl_valid);
    end
  endtask

  task automatic test_reset_mid(input bit use_rst);
    rec_t exp, got;
    q0.delete();
    fork
      send_frame(0, 8'hC3, 1'b0, 1'b1);
      begin
        repeat (BIT_CLKS * 5 + 8) @(negedge clk);
        vecs++;
        if (bus0.busy !== 1'b1) begin
          fails++;
          $display("FAIL rstmid_busy[%0d] got %b want 1", use_rst, bus0.busy);
        end
        if (use_rst) rst = 1'b1;
        else arst = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({bus0.rx_data, bus0.rx_valid, bus0.frame_err, bus0.parity_err, bus0.busy,
             bus0.baud_en, bus0.kick} !== 14'h0) begin
          fails++;
          $display("FAIL rstmid_outs[%0d] got %h want 0000", use_rst, {bus0.rx_data,
                   bus0.rx_valid, bus0.frame_err, bus0.parity_err, bus0.busy,
                   bus0.baud_en, bus0.kick});
        end
      end
    join
    rst = 1'b0;
    arst = 1'b1;
    repeat (10) @(negedge clk);
    vecs++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL rstmid_no_valid[%0d] got %0d want 0", use_rst, q0.size());
    end
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    exp = model(8'h5A, 1'b0, 1'b1, 1'b0);
    vecs++;
    if (q0.size() != 1) begin
      fails++;
      $display("FAIL rstmid_next_count[%0d] got %0d want 1", use_rst, q0.size());
    end else begin
      got = q0.pop_front();
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL rstmid_next_rec[%0d] got d=%h fe=%b pe=%b want d=5a fe=0 pe=0",
                 use_rst, got.d, got.fe, got.pe);
      end
    end
  endtask

  task automatic test_enable();
    rec_t exp, got;
    logic [7:0] d;
    int k;
    q0.delete();
    bus0.enable = 1'b0;
    @(negedge clk);
    k = kicks0;
    ben_off = 0;
    watch_off = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus0.rx = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    bus0.rx = 1'b1;
    repeat (5) @(negedge clk);
    watch_off = 1'b0;
    vecs++;
    if (ben_off != 0 || kicks0 != k || q0.size() != 0) begin
      fails++;
      $display("FAIL disabled_quiet active_cycles=%0d kicks=%0d valids=%0d want 0 %0d 0",
               ben_off, kicks0, q0.size(), k);
    end
    bus0.enable = 1'b1;
    repeat (5) @(negedge clk);
    fork
      send_frame(0, 8'($urandom), 1'b0, 1'b1);
      begin
        repeat (BIT_CLKS * 4 + 8) @(negedge clk);
        vecs++;
        if (bus0.busy !== 1'b1 || bus0.baud_en !== 1'b1) begin
          fails++;
          $display("FAIL abort_pre busy=%b baud_en=%b want 1 1", bus0.busy, bus0.baud_en);
        end
        bus0.enable = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus0.busy !== 1'b0 || bus0.baud_en !== 1'b0) begin
          fails++;
          $display("FAIL abort_busy_fall busy=%b baud_en=%b want 0 0", bus0.busy, bus0.baud_en);
        end
      end
    join
    bus0.enable = 1'b1;
    repeat (10) @(negedge clk);
    vecs++;
    if (q0.size() != 0 || bus0.rx_data !== 8'h5A || bus0.busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_hold valids=%0d d=%h busy=%b want 0 5a 0",
               q0.size(), bus0.rx_data, bus0.busy);
    end
    d = 8'($urandom);
    send_frame(0, d, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    exp = model(d, 1'b0, 1'b1, 1'b0);
    vecs++;
    if (q0.size() != 1) begin
      fails++;
      $display("FAIL abort_recover_count got %0d want 1", q0.size());
    end else begin
      got = q0.pop_front();
      vecs++;
      if (got !== exp) begin
        fails++;
        $display("FAIL abort_recover_rec got d=%h fe=%b pe=%b want d=%h fe=0 pe=0",
                 got.d, got.fe, got.pe, exp.d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_parity();
    test_back_to_back();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
